// File: rtl/cpi_calculator.sv
// Retired-instruction counter with halt-triggered CPI computation.
// Result is unsigned fixed point: cycles * 2^FRAC_W / instructions, truncated.
module cpi_calculator #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        i_cycle_count,
    input  logic                    i_instr_retired,
    input  logic                    i_processor_hlt,
    output logic [CNT_W-1:0]        o_instr_count,
    output logic [CNT_W-1:0]        o_cycles_latched,
    output logic [CNT_W+FRAC_W-1:0] o_cpi,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_div_by_zero
);

    localparam int Q_W  = CNT_W + FRAC_W;
    localparam int IT_W = $clog2(Q_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CNT_W-1:0] r_instr_count;
    logic [CNT_W-1:0] r_cycles_latched;
    logic [Q_W-1:0]   r_cpi;
    logic             r_div_by_zero;

    logic [Q_W-1:0]   r_quot;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_divisor;
    logic [IT_W-1:0]  r_iter;

    logic [CNT_W:0]   w_rem_shift;
    logic [CNT_W-1:0] w_rem_sub;
    logic             w_fits;
    logic [Q_W-1:0]   w_quot_next;
    logic             w_last_iter;

    // Stored remainder is always below the divisor, so it needs only CNT_W bits;
    // the shifted partial remainder carries the extra bit for the compare.
    always_comb begin
        w_rem_shift = {r_rem, r_quot[Q_W-1]};
        w_fits      = (w_rem_shift >= {1'b0, r_divisor});
        w_rem_sub   = w_rem_shift[CNT_W-1:0] - r_divisor;
        w_quot_next = {r_quot[Q_W-2:0], w_fits};
        w_last_iter = (r_iter == IT_W'(Q_W - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_processor_hlt) begin
                    w_next_state = S_LATCH;
                end
            end
            S_LATCH: begin
                if (r_instr_count == '0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (w_last_iter) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_DONE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_count    <= '0;
            r_cycles_latched <= '0;
            r_cpi            <= '0;
            r_div_by_zero    <= 1'b0;
            r_quot           <= '0;
            r_rem            <= '0;
            r_divisor        <= '0;
            r_iter           <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_instr_retired && (r_instr_count != '1)) begin
                        r_instr_count <= r_instr_count + 1'b1;
                    end
                end
                S_LATCH: begin
                    r_cycles_latched <= i_cycle_count;
                    if (r_instr_count == '0) begin
                        r_div_by_zero <= 1'b1;
                        r_cpi         <= '1;
                    end else begin
                        r_quot    <= {i_cycle_count, {FRAC_W{1'b0}}};
                        r_rem     <= '0;
                        r_divisor <= r_instr_count;
                        r_iter    <= '0;
                    end
                end
                S_DIVIDE: begin
                    r_rem  <= w_fits ? w_rem_sub : w_rem_shift[CNT_W-1:0];
                    r_quot <= w_quot_next;
                    r_iter <= r_iter + 1'b1;
                    if (w_last_iter) begin
                        r_cpi <= w_quot_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_instr_count    = r_instr_count;
    assign o_cycles_latched = r_cycles_latched;
    assign o_cpi            = r_cpi;
    assign o_div_by_zero    = r_div_by_zero;
    assign o_busy           = (r_state == S_LATCH) || (r_state == S_DIVIDE);
    assign o_done           = (r_state == S_DONE);

endmodule

// File: doc/cpi_calculator.md
CPI_CALCULATOR -- requirements
Module: cpi_calculator

Interface
REQ-001 Parameter CNT_W, default 16, width of cycle and instruction counts.
REQ-002 Parameter FRAC_W, default 8, fractional bits of the fixed-point CPI result.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_cycle_count  input  CNT_W  running cycle count from the cycle counter; freezes one edge after halt is first sampled.
REQ-006 i_instr_retired  input  1  single-cycle pulse per retired instruction.
REQ-007 i_processor_hlt  input  1  processor halt indication, level or pulse.
REQ-008 o_instr_count  output  CNT_W  retired-instruction count.
REQ-009 o_cycles_latched  output  CNT_W  final cycle count captured for the division.
REQ-010 o_cpi  output  CNT_W+FRAC_W  CPI, unsigned fixed point, CNT_W integer bits and FRAC_W fraction bits.
REQ-011 o_busy  output  1  high while in LATCH or DIVIDE.
REQ-012 o_done  output  1  high while in DONE; o_cpi, o_cycles_latched and o_div_by_zero are valid.
REQ-013 o_div_by_zero  output  1  high in DONE when o_instr_count is 0.

Function
REQ-014 FSM states: IDLE, LATCH, DIVIDE, DONE.
REQ-015 IDLE: o_instr_count increments by 1 on each edge with i_instr_retired=1, saturating at all-ones.
REQ-016 IDLE -> LATCH on the first edge with i_processor_hlt=1; an i_instr_retired pulse sampled on that same edge is counted.
REQ-017 From LATCH onward, i_instr_retired and i_processor_hlt are ignored and o_instr_count is frozen.
REQ-018 LATCH lasts exactly one cycle; on its exit edge o_cycles_latched <= i_cycle_count, so the capture includes the counter's final increment.
REQ-019 LATCH -> DONE if o_instr_count == 0: o_div_by_zero <= 1, o_cpi <= all-ones.
REQ-020 LATCH -> DIVIDE otherwise: dividend <= {i_cycle_count, FRAC_W zeros}, divisor <= o_instr_count, iteration counter <= 0.
REQ-021 DIVIDE: restoring shift-subtract division, one quotient bit per edge, MSB first, for exactly CNT_W+FRAC_W edges; the last edge enters DONE.
REQ-022 The result is floor((cycles * 2^FRAC_W) / instrs), truncated with no rounding.
REQ-023 The partial remainder is CNT_W+1 bits wide; no overflow is possible, because the quotient fits in CNT_W+FRAC_W bits for any divisor >= 1.
REQ-024 o_cpi updates only on DIVIDE->DONE or LATCH->DONE and holds 0 before that; it does not show intermediate quotient bits.
REQ-025 DONE is terminal and sticky until reset; o_done stays high.
REQ-026 Latency with halt sampled at edge E0: LATCH after E0; on the divide path, DIVIDE after E0+1 and o_done high after E0+1+CNT_W+FRAC_W (E0+25 at defaults).
REQ-027 On the zero-instruction path, o_done is high after E0+1.
REQ-028 i_cycle_count is sampled only on the LATCH exit edge; other values are ignored.

Reset
REQ-029 While reset=1, without waiting for a clock edge:
 - state = IDLE
 - o_instr_count, o_cycles_latched, o_cpi = 0
 - o_busy, o_done, o_div_by_zero = 0
 - divider registers cleared
REQ-030 Reset asserted in any state, including mid-DIVIDE, aborts the operation with no partial result retained.
REQ-031 After reset deasserts, counting resumes from 0 on the first edge.

Verification
REQ-032 10 retire pulses; halt; i_cycle_count=25 at LATCH exit -> o_cpi=0x000280 (2.50), o_done high after E0+25, o_busy high for 25 cycles.
REQ-033 No retire pulses; halt -> o_div_by_zero=1, o_cpi=0xFFFFFF, o_done high after E0+1.
REQ-034 1 retire pulse; i_cycle_count=0xFFFF at LATCH exit -> o_cpi=0xFFFF00, o_div_by_zero=0.
REQ-035 Retire pulse on the same edge as the first halt sample, plus retire pulses during DIVIDE -> the first is counted; o_instr_count is frozen afterwards.
REQ-036 70000 retire pulses -> o_instr_count=0xFFFF, with no wrap to 0.
REQ-037 Reset asserted at DIVIDE iteration 12 -> all outputs 0 immediately; after release, a new 3-instruction, 9-cycle run gives o_cpi=0x000300.
